// File: rtl/trigger_serializer_if.sv
// Symbol handshake between the 8b/10b encoder (master) and the trigger serializer (slave).
interface trigger_serializer_if;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;

  modport master (output sym_in, output sym_valid, input sym_ready);
  modport slave  (input sym_in, input sym_valid, output sym_ready);
endinterface

// File: rtl/trigger_serializer.sv
// Fixed-rate serializer for 10-bit trigger symbols; inserts K28.5 idles whenever
// no symbol is pending at a symbol boundary so the line never stalls.
module trigger_serializer #(
  parameter int         CLKS_PER_BIT = 4,
  parameter bit         LSB_FIRST    = 1'b1,
  parameter logic [9:0] IDLE_SYMBOL  = 10'h17C
) (
  input  logic                 clk,
  input  logic                 reset,
  trigger_serializer_if.slave  sym,
  output logic                 tx_out,
  output logic                 sym_start,
  output logic                 tx_active,
  output logic                 idle_inserted
);

  localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

  logic [9:0] sr;
  logic [7:0] clk_cnt;
  logic [3:0] bit_cnt;
  logic [9:0] hold;
  logic       hold_full;
  logic       is_user;

  logic bit_wrap, boundary, accept;

  assign bit_wrap  = (clk_cnt == CNT_MAX);
  assign boundary  = bit_wrap && (bit_cnt == 4'd9);
  assign accept    = sym.sym_valid && !hold_full;

  assign sym.sym_ready = !hold_full;
  assign tx_out        = LSB_FIRST ? sr[0] : sr[9];
  assign tx_active     = is_user;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr            <= IDLE_SYMBOL;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      is_user       <= 1'b0;
      sym_start     <= 1'b0;
      idle_inserted <= 1'b0;
    end else begin
      sym_start     <= 1'b0;
      idle_inserted <= 1'b0;
      clk_cnt       <= bit_wrap ? '0 : clk_cnt + 8'd1;

      if (boundary) begin
        bit_cnt   <= '0;
        sym_start <= 1'b1;
        // Held symbol wins; a same-cycle accept bypasses the hold entirely.
        if (hold_full) begin
          sr        <= hold;
          hold_full <= 1'b0;
          is_user   <= 1'b1;
        end else if (accept) begin
          sr      <= sym.sym_in;
          is_user <= 1'b1;
        end else begin
          sr            <= IDLE_SYMBOL;
          is_user       <= 1'b0;
          idle_inserted <= 1'b1;
        end
      end else begin
        if (bit_wrap) begin
          bit_cnt <= bit_cnt + 4'd1;
          sr      <= LSB_FIRST ? {1'b0, sr[9:1]} : {sr[8:0], 1'b0};
        end
        if (accept) begin
          hold      <= sym.sym_in;
          hold_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trigger_serializer.sv
// Directed bench: default serializer (CPB=4, LSB first) plus an MSB-first CPB=1 instance.
module tb_trigger_serializer;

  logic clk = 1'b0;
  logic reset, rst_b;
  logic a_tx, a_start, a_active, a_idle;
  logic b_tx, b_start, b_active, b_idle;

  int n = 0;
  int checks = 0;
  int failures = 0;

  logic [9:0] idle_v = 10'h17C;
  logic [9:0] d2aa   = 10'h2AA;
  logic [9:0] s201   = 10'h201;
  logic [9:0] s3c0   = 10'h3C0;
  logic [9:0] syms [3] = '{10'h2AA, 10'h155, 10'h0F3};

  trigger_serializer_if ia ();
  trigger_serializer_if ib ();

  trigger_serializer dut_a (
    .clk(clk), .reset(reset), .sym(ia.slave),
    .tx_out(a_tx), .sym_start(a_start), .tx_active(a_active), .idle_inserted(a_idle)
  );

  trigger_serializer #(.CLKS_PER_BIT(1), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .sym(ib.slave),
    .tx_out(b_tx), .sym_start(b_start), .tx_active(b_active), .idle_inserted(b_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic chk_reset_a();
    chk("rst_tx",     32'(a_tx),         32'd0);
    chk("rst_ready",  32'(ia.sym_ready), 32'd1);
    chk("rst_active", 32'(a_active),     32'd0);
    chk("rst_start",  32'(a_start),      32'd0);
    chk("rst_idle",   32'(a_idle),       32'd0);
  endtask

  // Idle-only traffic starting from the reset state (n == 0).
  task automatic idle_run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk("idle_tx",     32'(a_tx),         32'(idle_v[(n / 4) % 10]));
      chk("idle_start",  32'(a_start),      32'((n % 40 == 0) && (n > 0)));
      chk("idle_ins",    32'(a_idle),       32'((n % 40 == 0) && (n > 0)));
      chk("idle_active", 32'(a_active),     32'd0);
      chk("idle_ready",  32'(ia.sym_ready), 32'd1);
      tick();
    end
  endtask

  initial begin
    int  idx;
    logic acc;
    reset = 1'b1; rst_b = 1'b1;
    ia.sym_valid = 1'b0; ia.sym_in = '0;
    ib.sym_valid = 1'b0; ib.sym_in = '0;
    tick(); tick(); tick();
    chk_reset_a();
    reset = 1'b0;
    n = 0;

    // Free-running idle
    idle_run(80);

    // Single symbol accepted mid-symbol, held until the next boundary
    run_to(85);
    ia.sym_valid = 1'b1; ia.sym_in = 10'h2AA;
    tick();
    ia.sym_valid = 1'b0;
    chk("single_ready_drop", 32'(ia.sym_ready), 32'd0);
    run_to(100);
    chk("single_ready_hold", 32'(ia.sym_ready), 32'd0);
    run_to(119);
    chk("single_pre_start", 32'(a_start), 32'd0);
    tick();
    chk("single_start",  32'(a_start),      32'd1);
    chk("single_idle",   32'(a_idle),       32'd0);
    chk("single_ready",  32'(ia.sym_ready), 32'd1);
    for (int k = 0; k < 40; k++) begin
      chk("single_tx",     32'(a_tx),     32'(d2aa[k / 4]));
      chk("single_active", 32'(a_active), 32'd1);
      tick();
    end
    chk("single_end_start",  32'(a_start),  32'd1);
    chk("single_end_idle",   32'(a_idle),   32'd1);
    chk("single_end_active", 32'(a_active), 32'd0);

    // Back-to-back symbols with sym_valid held high
    run_to(165);
    idx = 0;
    while (n < 330) begin
      ia.sym_in    = syms[idx < 3 ? idx : 2];
      ia.sym_valid = (idx < 3);
      if (n == 200 || n == 240 || n == 280) begin
        chk("b2b_start",  32'(a_start),      32'd1);
        chk("b2b_active", 32'(a_active),     32'd1);
        chk("b2b_idle",   32'(a_idle),       32'd0);
        chk("b2b_ready",  32'(ia.sym_ready), 32'd1);
        chk("b2b_bit0",   32'(a_tx),         32'(syms[(n - 200) / 40][0]));
      end
      if (n == 201 || n == 241)
        chk("b2b_ready_drop", 32'(ia.sym_ready), 32'd0);
      if (n == 204 || n == 244 || n == 284)
        chk("b2b_bit1", 32'(a_tx), 32'(syms[(n - 204) / 40][1]));
      if (n == 320) begin
        chk("b2b_resume_idle",   32'(a_idle),   32'd1);
        chk("b2b_resume_active", 32'(a_active), 32'd0);
        chk("b2b_resume_start",  32'(a_start),  32'd1);
      end
      acc = ia.sym_valid && ia.sym_ready;
      tick();
      if (acc) idx++;
    end
    ia.sym_valid = 1'b0;
    chk("b2b_all_taken", 32'(idx), 32'd3);

    // Bypass: valid first raised on a boundary cycle
    run_to(359);
    chk("byp_pre_ready", 32'(ia.sym_ready), 32'd1);
    ia.sym_valid = 1'b1; ia.sym_in = 10'h3C0;
    tick();
    ia.sym_valid = 1'b0;
    chk("byp_start",  32'(a_start),  32'd1);
    chk("byp_active", 32'(a_active), 32'd1);
    chk("byp_idle",   32'(a_idle),   32'd0);
    chk("byp_bit0",   32'(a_tx),     32'(s3c0[0]));
    for (int k = 0; k < 40; k++) begin
      chk("byp_ready", 32'(ia.sym_ready), 32'd1);
      if (n == 384) chk("byp_bit6", 32'(a_tx), 32'(s3c0[6]));
      tick();
    end
    chk("byp_end_idle", 32'(a_idle), 32'd1);

    // Reset in the middle of a user symbol with another one held
    run_to(405);
    ia.sym_valid = 1'b1; ia.sym_in = 10'h2AA;
    tick();
    ia.sym_valid = 1'b0;
    run_to(440);
    chk("rmid_start",  32'(a_start),  32'd1);
    chk("rmid_active", 32'(a_active), 32'd1);
    ia.sym_valid = 1'b1; ia.sym_in = 10'h155;
    tick();
    ia.sym_valid = 1'b0;
    chk("rmid_held", 32'(ia.sym_ready), 32'd0);
    run_to(460);
    reset = 1'b1;
    tick(); tick();
    chk_reset_a();
    reset = 1'b0;
    n = 0;
    idle_run(80);

    // MSB-first, one clock per bit
    rst_b = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 3) begin ib.sym_valid = 1'b1; ib.sym_in = 10'h201; end
      if (k == 4) begin
        ib.sym_valid = 1'b0;
        chk("msb_ready_drop", 32'(ib.sym_ready), 32'd0);
      end
      if (k == 10) chk("msb_ready_rise", 32'(ib.sym_ready), 32'd1);
      if (k < 10)      chk("msb_tx", 32'(b_tx), 32'(idle_v[9 - k]));
      else if (k < 20) chk("msb_tx", 32'(b_tx), 32'(s201[19 - k]));
      else             chk("msb_tx", 32'(b_tx), 32'(idle_v[29 - k]));
      chk("msb_start",  32'(b_start),  32'(k == 10 || k == 20));
      chk("msb_active", 32'(b_active), 32'(k >= 10 && k < 20));
      chk("msb_idle",   32'(b_idle),   32'(k == 20));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trigger_serializer.md
# trigger_serializer

Serializes the 10-bit 8b/10b symbols produced by the trigger CRC/8b10b encoding stage onto a single-bit trigger line. Sits directly downstream of the encoder and accepts symbols through a valid/ready handshake with a one-entry holding register. Outputs each symbol at a fixed bit rate of one bit per CLKS_PER_BIT clocks. When no symbol is pending at a symbol boundary, it transmits a comma (K28.5) idle symbol, so the line never stalls and the far end can keep alignment.

## Interface
- CLKS_PER_BIT, 4, clocks per serial bit; legal range 1..255.
- LSB_FIRST, 1, 1 = transmit sym bit 0 (8b/10b bit "a") first; 0 = transmit bit 9 first.
- IDLE_SYMBOL, 10'h17C, symbol inserted when no data is pending (K28.5 RD-, bit 0 = "a").

- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- sym_in  in  10  encoded symbol from the 8b/10b encoder.
- sym_valid  in  1  sym_in holds a symbol to send.
- sym_ready  out  1  block can accept a symbol this cycle.
- tx_out  out  1  serial trigger line.
- sym_start  out  1  one-cycle pulse on the first clock of every transmitted symbol.
- tx_active  out  1  high for the whole period of a user symbol; low during idle symbols.
- idle_inserted  out  1  one-cycle pulse, coincident with sym_start, when an idle symbol starts.

## Operation
- State:
  - 10-bit shift register `sr`.
  - Clock divider `clk_cnt` (0..CLKS_PER_BIT-1).
  - Bit counter `bit_cnt` (0..9).
  - Holding register `hold` with flag `hold_full`.
  - Registered source flag `is_user`.
- sym_ready = !hold_full, driven from the register with no combinational path from sym_valid.
- Accept = sym_valid && sym_ready.
- Bit advance: `clk_cnt` increments each cycle and wraps at CLKS_PER_BIT-1. On the wrap, `bit_cnt` increments and `sr` shifts one position toward the output end.
- Boundary cycle: clk_cnt == CLKS_PER_BIT-1 && bit_cnt == 9. On a boundary, the next symbol is chosen by priority:
  1. hold_full: load `sr` from `hold` and clear hold_full. A simultaneous accept is impossible, because sym_ready is low.
  2. Accept in this cycle: bypass, loading `sr` directly from sym_in; hold stays empty.
  3. Otherwise: load IDLE_SYMBOL.
- `is_user` is set to 1 for cases 1–2 and to 0 for case 3.
- An accept on a non-boundary cycle writes `hold` and sets hold_full.
- tx_out = sr[0] when LSB_FIRST, else sr[9]. The shift direction follows the same parameter.
- No data inspection: any 10-bit value is sent verbatim, and disparity is the encoder's responsibility.

## Timing
- Reset values:
  - sr = IDLE_SYMBOL; clk_cnt = 0; bit_cnt = 0; hold_full = 0; is_user = 0.
  - sym_ready = 1; tx_out = IDLE_SYMBOL first bit (0 for default); tx_active = 0.
  - sym_start = 0; idle_inserted = 0.
- The first symbol after reset is the reset-loaded idle. It does not assert sym_start or idle_inserted; the first pulses occur on the following boundary.
- Symbol period: exactly 10*CLKS_PER_BIT cycles. sym_start pulses every period, with no gaps and no jitter.
- sym_start, idle_inserted and tx_active are registered and change on the first cycle of the new symbol, the same cycle its first bit appears on tx_out.
- Latency, accept on a non-boundary cycle t: the symbol's first bit appears on the cycle after the next boundary.
- Latency, accept on boundary cycle t (bypass): the first bit appears at t+1.
- Back-to-back: with sym_valid held high, the block accepts one symbol per period. sym_ready drops the cycle after the hold is filled and rises the cycle after the hold is drained at the boundary.
- Reset asserted mid-symbol: the symbol in flight and the hold contents are discarded. From the cycle after reset deasserts, the line restarts at bit 0 of IDLE_SYMBOL.
- CLKS_PER_BIT = 1: every cycle is a bit advance, and the boundary is bit_cnt == 9.

## Test plan
- Reset, no traffic, CPB=4:
  - tx_out repeats the bit pattern of 0x17C LSB-first (0,0,1,1,1,1,1,0,1,0), each bit held 4 cycles.
  - sym_start and idle_inserted pulse every 40 cycles; tx_active stays 0; sym_ready stays 1.
- Single symbol 10'h2AA accepted mid-idle:
  - sym_ready goes 0 the next cycle; the symbol starts on the cycle after the boundary.
  - tx_out shows 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit; tx_active is 1 for 40 cycles; idle_inserted is 0 for that symbol.
- Continuous sym_valid, symbols 0x2AA, 0x155, 0x0F3:
  - All three are transmitted in consecutive periods with no idle between them, and sym_ready toggles once per period.
  - Idle resumes after the last symbol, with idle_inserted = 1.
- sym_valid first asserted exactly on a boundary cycle (bypass), symbol 0x3C0:
  - The symbol starts the next cycle; hold_full never sets, so sym_ready stays 1.
- Reset asserted at bit 5 of a user symbol, with a second symbol held:
  - After reset, the idle pattern restarts from bit 0, and neither user symbol is ever transmitted.
  - All outputs take their reset values.
- LSB_FIRST=0, CPB=1, symbol 10'h201:
  - tx_out sequence is 1,0,0,0,0,0,0,0,0,1, with one bit per cycle and a period of 10 cycles.
